// File: rtl/mux_scan_serializer_pkg.sv
// Shared widths, FSM encoding and select-order helpers for the mux scan serializer.
package mux_scan_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [SEL_W-1:0] SEL_LO = 3'd0;
    localparam logic [SEL_W-1:0] SEL_HI = 3'd7;

    typedef struct packed {
        logic bit_val;
        logic valid;
        logic last;
    } ser_flags_t;

    function automatic logic [SEL_W-1:0] start_sel(input bit lsb_first);
        return lsb_first ? SEL_LO : SEL_HI;
    endfunction

    function automatic logic [SEL_W-1:0] end_sel(input bit lsb_first);
        return lsb_first ? SEL_HI : SEL_LO;
    endfunction

endpackage

// File: rtl/mux_scan_serializer_bit_tick_divider.sv
// Bit-period divider: tick marks the last cycle of each BIT_CYCLES-long serial bit.
module bit_tick_divider #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(BIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_serializer.sv
// Loads a byte onto an external 8:1 mux, scans its select through all positions
// and returns the sampled mux output as a registered serial stream.
module mux_scan_serializer
    import mux_scan_pkg::*;
#(
    parameter int BIT_CYCLES = 1,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              abort,
    output logic [DATA_W-1:0] mux_data_in,
    output logic [SEL_W-1:0]  mux_sel,
    input  logic              mux_bit,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy
);

    localparam logic [SEL_W-1:0] START_SEL = start_sel(LSB_FIRST);
    localparam logic [SEL_W-1:0] END_SEL   = end_sel(LSB_FIRST);
    localparam logic [2:0]       LAST_BIT  = 3'd7;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    ser_flags_t        ser_q, ser_d;

    logic div_clr, div_en, tick;

    // Divider is held cleared outside SHIFT and on abort, so every frame starts a fresh bit period.
    assign div_clr = (state_q == IDLE) || abort;
    assign div_en  = (state_q == SHIFT) && !abort;

    bit_tick_divider #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .clr (div_clr),
        .en  (div_en),
        .tick(tick)
    );

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        sel_d       = sel_q;
        bitcnt_d    = bitcnt_q;
        ser_d       = ser_q;
        ser_d.valid = 1'b0;
        ser_d.last  = 1'b0;

        if (state_q == IDLE) begin
            if (load_valid) begin
                data_d   = load_data;
                sel_d    = START_SEL;
                bitcnt_d = '0;
                state_d  = SHIFT;
            end
        end else begin
            if (abort) begin
                state_d  = IDLE;
                bitcnt_d = '0;
                sel_d    = START_SEL;
            end else if (tick) begin
                ser_d.bit_val = mux_bit;
                ser_d.valid   = 1'b1;
                ser_d.last    = (bitcnt_q == LAST_BIT);
                bitcnt_d      = bitcnt_q + 3'd1;
                // After the eighth sample the select parks at the start index instead of wrapping.
                if (bitcnt_q == LAST_BIT) begin
                    state_d = IDLE;
                    sel_d   = START_SEL;
                end else if (sel_q != END_SEL) begin
                    sel_d = LSB_FIRST ? sel_q + 3'd1 : sel_q - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            sel_q    <= START_SEL;
            bitcnt_q <= '0;
            ser_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            bitcnt_q <= bitcnt_d;
            ser_q    <= ser_d;
        end
    end

    assign load_ready  = (state_q == IDLE);
    assign busy        = (state_q == SHIFT);
    assign mux_data_in = data_q;
    assign mux_sel     = sel_q;
    assign ser_out     = ser_q.bit_val;
    assign ser_valid   = ser_q.valid;
    assign ser_last    = ser_q.last;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer: six instances (BIT_CYCLES 1..5 LSB-first, plus 3 MSB-first) each with a behavioural mux.
module tb_mux_scan_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] lv, lr, ab, so, sv, sl, by, mb;
    logic [7:0] ld   [6];
    logic [7:0] mdi  [6];
    logic [2:0] msel [6];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    bit bq [6][$];
    int vc [6][$];
    int lastn [6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 6; g++) begin : g_dut
        localparam int BC = (g == 5) ? 3 : g + 1;
        localparam bit LF = (g == 5) ? 1'b0 : 1'b1;
        mux_scan_serializer #(
            .BIT_CYCLES(BC),
            .LSB_FIRST (LF)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .load_valid (lv[g]),
            .load_ready (lr[g]),
            .load_data  (ld[g]),
            .abort      (ab[g]),
            .mux_data_in(mdi[g]),
            .mux_sel    (msel[g]),
            .mux_bit    (mb[g]),
            .ser_out    (so[g]),
            .ser_valid  (sv[g]),
            .ser_last   (sl[g]),
            .busy       (by[g])
        );
        assign mb[g] = mdi[g][msel[g]];
    end

    // Reference capture: every ser_valid contributes one bit and its cycle stamp.
    always @(negedge clk) begin
        for (int k = 0; k < 6; k++) begin
            if (sv[k]) begin
                bq[k].push_back(so[k]);
                vc[k].push_back(cyc);
                if (sl[k]) lastn[k]++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clrq(input int g);
        bq[g].delete();
        vc[g].delete();
        lastn[g] = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b, got;
        logic [15:0] w16;
        int          g, bc, w, c0;
        bit          lf;

        rst = 1'b1;
        lv  = '0;
        ab  = '0;
        for (int k = 0; k < 6; k++) begin
            ld[k]    = '0;
            lastn[k] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_ready", 32'(lr), 32'h3F);
        chk("rst_busy", 32'(by), 0);
        chk("rst_valid", 32'(sv), 0);
        chk("rst_last", 32'(sl), 0);
        chk("rst_out", 32'(so), 0);
        chk("rst_data0", 32'(mdi[0]), 0);
        chk("rst_sel0", 32'(msel[0]), 0);
        chk("rst_sel5", 32'(msel[5]), 7);

        // A5, BIT_CYCLES=1, LSB first
        b = 8'hA5;
        ld[0] = b;
        lv[0] = 1'b1;
        @(negedge clk);
        lv[0] = 1'b0;
        chk("t1_ready_low", 32'(lr[0]), 0);
        chk("t1_busy", 32'(by[0]), 1);
        chk("t1_data", 32'(mdi[0]), 32'hA5);
        chk("t1_sel", 32'(msel[0]), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t1_valid", 32'(sv[0]), 1);
            chk("t1_bit", 32'(so[0]), 32'(b[i]));
            chk("t1_last", 32'(sl[0]), 32'(i == 7));
            chk("t1_ready", 32'(lr[0]), 32'(i == 7));
        end
        @(negedge clk);
        chk("t1_valid_end", 32'(sv[0]), 0);

        // 81, BIT_CYCLES=3, MSB first: select 7..0 each held 3 cycles
        b = 8'h81;
        ld[5] = b;
        lv[5] = 1'b1;
        @(negedge clk);
        lv[5] = 1'b0;
        for (int j = 0; j <= 24; j++) begin
            if (j > 0) @(negedge clk);
            chk("t2_valid", 32'(sv[5]), 32'(j > 0 && j % 3 == 0));
            chk("t2_sel", 32'(msel[5]), (j == 24) ? 7 : 7 - j / 3);
            chk("t2_last", 32'(sl[5]), 32'(j == 24));
            if (j > 0 && j % 3 == 0) chk("t2_bit", 32'(so[5]), 32'(b[8 - j / 3]));
        end
        @(negedge clk);

        // load_valid held high: 0F then F0 back to back
        clrq(0);
        ld[0] = 8'h0F;
        lv[0] = 1'b1;
        @(negedge clk);
        ld[0] = 8'hF0;
        repeat (4) @(negedge clk);
        chk("t3_data_hold", 32'(mdi[0]), 32'h0F);
        chk("t3_ready_busy", 32'(lr[0]), 0);
        repeat (5) @(negedge clk);
        chk("t3_second_busy", 32'(by[0]), 1);
        chk("t3_second_data", 32'(mdi[0]), 32'hF0);
        lv[0] = 1'b0;
        repeat (10) @(negedge clk);
        w16 = '0;
        for (int i = 0; i < bq[0].size() && i < 16; i++) w16[i] = bq[0][i];
        chk("t3_count", bq[0].size(), 16);
        chk("t3_bits", 32'(w16), 32'hF00F);
        chk("t3_lasts", lastn[0], 2);

        // abort after the third bit of FF
        clrq(0);
        ld[0] = 8'hFF;
        lv[0] = 1'b1;
        @(negedge clk);
        lv[0] = 1'b0;
        repeat (3) @(negedge clk);
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        chk("t4_valid", 32'(sv[0]), 0);
        chk("t4_last", 32'(sl[0]), 0);
        chk("t4_ready", 32'(lr[0]), 1);
        chk("t4_busy", 32'(by[0]), 0);
        chk("t4_sel", 32'(msel[0]), 0);
        chk("t4_data_hold", 32'(mdi[0]), 32'hFF);
        repeat (12) @(negedge clk);
        chk("t4_count", bq[0].size(), 3);
        chk("t4_lasts", lastn[0], 0);

        // abort in IDLE with a load: load wins
        ld[0] = 8'h3C;
        lv[0] = 1'b1;
        ab[0] = 1'b1;
        @(negedge clk);
        lv[0] = 1'b0;
        ab[0] = 1'b0;
        chk("t4b_busy", 32'(by[0]), 1);
        chk("t4b_data", 32'(mdi[0]), 32'h3C);
        repeat (10) @(negedge clk);

        // asynchronous reset mid-frame
        ld[0] = 8'h5A;
        lv[0] = 1'b1;
        @(negedge clk);
        lv[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_ready", 32'(lr), 32'h3F);
        chk("t5_busy", 32'(by), 0);
        chk("t5_valid", 32'(sv), 0);
        chk("t5_out", 32'(so), 0);
        chk("t5_data0", 32'(mdi[0]), 0);
        chk("t5_sel0", 32'(msel[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clrq(0);
        ld[0] = 8'h01;
        lv[0] = 1'b1;
        @(negedge clk);
        lv[0] = 1'b0;
        repeat (10) @(negedge clk);
        got = '0;
        for (int i = 0; i < bq[0].size() && i < 8; i++) got[i] = bq[0][i];
        chk("t5_count", bq[0].size(), 8);
        chk("t5_byte", 32'(got), 32'h01);

        // Random bytes across BIT_CYCLES 1..5 and both orders
        for (int n = 0; n < 256; n++) begin
            g  = $urandom_range(0, 5);
            bc = (g == 5) ? 3 : g + 1;
            lf = (g != 5);
            b  = 8'($urandom);
            clrq(g);
            ld[g] = b;
            lv[g] = 1'b1;
            @(negedge clk);
            lv[g] = 1'b0;
            c0 = cyc;
            w  = 0;
            while (!lr[g] && w < 200) begin
                @(negedge clk);
                w++;
            end
            @(negedge clk);
            chk("rnd_period", w, 8 * bc);
            chk("rnd_count", bq[g].size(), 8);
            got = '0;
            for (int i = 0; i < bq[g].size() && i < 8; i++) got[lf ? i : 7 - i] = bq[g][i];
            chk("rnd_byte", 32'(got), 32'(b));
            chk("rnd_lasts", lastn[g], 1);
            chk("rnd_first_t", (bq[g].size() > 0) ? vc[g][0] : -1, c0 + bc);
            chk("rnd_last_t", (bq[g].size() == 8) ? vc[g][7] : -1, c0 + 8 * bc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
Upstream sequencer for the 8:1 bit-select mux (mux8to1).
- Accepts a byte over a valid/ready handshake and presents it on the mux data inputs.
- Steps the mux select through all 8 positions, samples the mux output at each step, and emits the bits as a registered serial stream with valid and last-bit strobes.
- Sits between a byte producer and a serial consumer; the mux is instantiated alongside it, not inside it.

Parameters:
- BIT_CYCLES, 1, clock cycles per serial bit (>=1); divider counter width is $clog2(BIT_CYCLES+1).
- LSB_FIRST, 1, 1: select order 0->7; 0: select order 7->0.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  byte offered.
- load_ready  out  1  block can accept a byte (IDLE only).
- load_data  in  8  byte to serialize.
- abort  in  1  synchronous cancel of the current frame.
- mux_data_in  out  8  registered byte driven to the mux data inputs.
- mux_sel  out  3  registered select driven to the mux.
- mux_bit  in  1  mux output; combinational return path.
- ser_out  out  1  registered serial bit.
- ser_valid  out  1  one-cycle strobe; ser_out is valid this cycle.
- ser_last  out  1  high with ser_valid on the 8th bit of a frame.
- busy  out  1  high in SHIFT.

Behaviour:
- Reset (async assert, any state):
  - state=IDLE, load_ready=1, busy=0.
  - mux_data_in=0, mux_sel=0 (LSB_FIRST=1) or 7 (LSB_FIRST=0).
  - ser_out=0, ser_valid=0, ser_last=0, divider=0, bit counter=0.
- States:
  - IDLE: load_ready=1, busy=0. On the edge where load_valid && load_ready:
    - mux_data_in<=load_data, mux_sel<=start index, divider<=0, bitcnt<=0, state<=SHIFT.
    - load_ready drops the following cycle.
  - SHIFT: load_ready=0, busy=1. The divider counts 0..BIT_CYCLES-1. On the edge where divider==BIT_CYCLES-1:
    - ser_out<=mux_bit, ser_valid<=1, ser_last<=(bitcnt==7).
    - divider<=0, bitcnt<=bitcnt+1, mux_sel steps by +1 (LSB_FIRST) or -1.
    - If bitcnt==7: state<=IDLE and mux_sel<=start index, with no wrap beyond the 8th sample.
    - On all other edges: ser_valid<=0, ser_last<=0, ser_out holds.
- mux_data_in and mux_sel change only on bit-boundary edges or on load, so the mux output settles for a full BIT_CYCLES period before sampling.
- Latency (BIT_CYCLES=1):
  - Load accepted at edge E0.
  - Bits sampled at E1..E8; ser_valid high in the cycles after E1..E8.
  - load_ready=1 again after E8.
  - Minimum frame period 9 cycles. General case: 8*BIT_CYCLES+1 cycles.
- Boundary conditions:
  - load_valid while busy: ignored, load_ready=0, nothing is captured.
  - load_valid held high in IDLE after a frame: the next byte is accepted on the first IDLE cycle.
  - abort in SHIFT: next edge forces state=IDLE, divider=0, bitcnt=0, mux_sel=start index, ser_valid=0, ser_last=0. No partial last strobe. mux_data_in holds.
  - abort in IDLE: no effect; load acceptance has priority over abort in the same cycle.
  - Reset mid-frame: immediate return to reset values; the frame is discarded.
- ser_valid and ser_last never assert outside SHIFT. Exactly 8 ser_valid pulses and 1 ser_last per unaborted frame.

Decomposition:
- Package mux_scan_pkg:
  - localparams DATA_W=8, SEL_W=3.
  - State encoding IDLE=1'b0, SHIFT=1'b1.
  - Helper constant for the start/end select index per LSB_FIRST.
- One sub-module, bit_tick_divider (parameter BIT_CYCLES; inputs clk, rst, clr, en; output tick):
  - tick is high when the count equals BIT_CYCLES-1 and en=1.
  - The serializer FSM consumes tick as its bit-boundary strobe.

Test Plan:
- BIT_CYCLES=1, LSB_FIRST=1: load 8'hA5 -> ser_out sequence 1,0,1,0,0,1,0,1 on 8 consecutive ser_valid cycles; ser_last on the 8th; load_ready back 9 cycles after accept.
- BIT_CYCLES=3, LSB_FIRST=0: load 8'h81 -> bits 1,0,0,0,0,0,0,1 with ser_valid every 3rd cycle; mux_sel sequence 7..0, each held 3 cycles.
- load_valid held high with 8'h0F then 8'hF0: first frame 1,1,1,1,0,0,0,0 (LSB first), second accepted on the IDLE cycle right after; second byte ignored while busy.
- abort asserted after the 3rd ser_valid of 8'hFF -> no further ser_valid, no ser_last, load_ready=1 next cycle, mux_sel=0.
- rst pulsed mid-frame (asynchronous, between edges) -> all outputs at reset values immediately; after release, load 8'h01 serializes correctly.
- Bench connects a behavioural mux8to1 to mux_data_in/mux_sel/mux_bit and checks the serialized byte equals the loaded byte for 256 random values at random BIT_CYCLES (1..5).
